// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two prioritised write ports,
// optional write-to-read bypass, pending scoreboard and bulk-clear sweep.
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.

module reg_file_mp #(
   parameter int W      = 8,
   parameter int A      = 4,
   parameter int NR     = 2,
   parameter int BYPASS = 1
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            ClearReq,
   output logic            Busy,
   input  logic            WriteEn0,
   input  logic [A-1:0]    Waddr0,
   input  logic [W-1:0]    DataIn0,
   input  logic            WriteEn1,
   input  logic [A-1:0]    Waddr1,
   input  logic [W-1:0]    DataIn1,
   input  logic            IssueEn,
   input  logic [A-1:0]    IssueAddr,
   input  logic [NR*A-1:0] Raddr,
   output logic [NR*W-1:0] DataOut,
   output logic [NR-1:0]   Pending
);

   localparam int D = 1 << A;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t         state, state_nxt;
   logic [A-1:0]   cnt, cnt_nxt;
   logic [W-1:0]   regs [D];
   logic [D-1:0]   pend, pend_nxt;
   logic           busy;
   logic           ok0, ok1, oki;
   logic           we0, we1, iss;

`ifdef REGFILE_ZERO_REG_EN
   assign ok0 = |Waddr0;
   assign ok1 = |Waddr1;
   assign oki = |IssueAddr;
`else
   assign ok0 = 1'b1;
   assign ok1 = 1'b1;
   assign oki = 1'b1;
`endif

   assign busy = (state == SWEEP);
   assign Busy = busy;

   // Ports are frozen while the sweep owns the array
   assign we0 = WriteEn0 & ~busy & ok0;
   assign we1 = WriteEn1 & ~busy & ok1;
   assign iss = IssueEn  & ~busy & oki;

   // Sweep FSM state and counter
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Sweep next-state: one entry per cycle, stop on all-ones
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (ClearReq) begin
               state_nxt = SWEEP;
               cnt_nxt   = '0;
            end
         end
         SWEEP: begin
            if (cnt == {A{1'b1}}) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Register array; port 0 written last so it wins a collision
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int j = 0; j < D; j++) regs[j] <= '0;
      end else if (busy) begin
         regs[cnt] <= '0;
      end else begin
         if (we1) regs[Waddr1] <= DataIn1;
         if (we0) regs[Waddr0] <= DataIn0;
      end
   end

   // Scoreboard update: writes clear, issue sets and wins
   always_comb begin
      pend_nxt = pend;
      if (we0) pend_nxt[Waddr0] = 1'b0;
      if (we1) pend_nxt[Waddr1] = 1'b0;
      if (iss) pend_nxt[IssueAddr] = 1'b1;
   end

   // Scoreboard register
   always_ff @(posedge Clk) begin
      if (Reset)     pend      <= '0;
      else if (busy) pend[cnt] <= 1'b0;
      else           pend      <= pend_nxt;
   end

   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [A-1:0] ra;
      logic         h0, h1, hi;
      logic [W-1:0] d;
      logic         p;

      assign ra = Raddr[i*A +: A];
      assign h0 = we0 && (Waddr0 == ra);
      assign h1 = we1 && (Waddr1 == ra);
      assign hi = iss && (IssueAddr == ra);

      // Read port: stored value, optionally overridden by this cycle's write
      always_comb begin
         d = regs[ra];
         p = pend[ra];
         if ((BYPASS != 0) && (h0 || h1)) begin
            d = h0 ? DataIn0 : DataIn1;
            if (!hi) p = 1'b0;
         end
`ifdef REGFILE_ZERO_REG_EN
         if (ra == '0) begin
            d = '0;
            p = 1'b0;
         end
`endif
      end

      assign DataOut[i*W +: W] = d;
      assign Pending[i]        = p;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed vector table, sweep/reset sequences and
// randomized traffic against an array-based reference model.

module tb_reg_file_mp;

   logic        Clk = 1'b0;
   logic        Reset, ClearReq, Busy;
   logic        WriteEn0, WriteEn1, IssueEn;
   logic [3:0]  Waddr0, Waddr1, IssueAddr;
   logic [7:0]  DataIn0, DataIn1;
   logic [7:0]  Raddr;
   logic [15:0] DataOut;
   logic [1:0]  Pending;

   int tests = 0;
   int fails = 0;

`ifdef REGFILE_ZERO_REG_EN
   localparam logic [7:0] R0V  = 8'h00;
   localparam logic       R0P  = 1'b0;
   localparam logic [7:0] R0FF = 8'h00;
`else
   localparam logic [7:0] R0V  = 8'h55;
   localparam logic       R0P  = 1'b1;
   localparam logic [7:0] R0FF = 8'hFF;
`endif

   typedef struct {
      logic       we0;
      logic [3:0] wa0;
      logic [7:0] d0;
      logic       we1;
      logic [3:0] wa1;
      logic [7:0] d1;
      logic       iss;
      logic [3:0] ia;
      logic [3:0] ra0, ra1;
      logic [7:0] e0, e1;
      logic [1:0] ep;
   } vec_t;

   vec_t tbl [14];

   logic [7:0] mreg  [16];
   logic       mpend [16];
   int         msw;

   always #5 Clk = ~Clk;

   reg_file_mp #(.W(8), .A(4), .NR(2), .BYPASS(1)) dut (
      .Clk(Clk), .Reset(Reset), .ClearReq(ClearReq), .Busy(Busy),
      .WriteEn0(WriteEn0), .Waddr0(Waddr0), .DataIn0(DataIn0),
      .WriteEn1(WriteEn1), .Waddr1(Waddr1), .DataIn1(DataIn1),
      .IssueEn(IssueEn), .IssueAddr(IssueAddr),
      .Raddr(Raddr), .DataOut(DataOut), .Pending(Pending)
   );

   task automatic chk(input string nm, input logic [19:0] act,
                      input logic [19:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_in();
      ClearReq = 1'b0;
      WriteEn0 = 1'b0; Waddr0 = '0; DataIn0 = '0;
      WriteEn1 = 1'b0; Waddr1 = '0; DataIn1 = '0;
      IssueEn  = 1'b0; IssueAddr = '0;
   endtask

   function automatic vec_t mk(int we0, int wa0, int d0, int we1, int wa1,
                               int d1, int iss, int ia, int ra0, int ra1,
                               int e0, int e1, int ep);
      vec_t v;
      v.we0 = 1'(we0); v.wa0 = 4'(wa0); v.d0 = 8'(d0);
      v.we1 = 1'(we1); v.wa1 = 4'(wa1); v.d1 = 8'(d1);
      v.iss = 1'(iss); v.ia  = 4'(ia);
      v.ra0 = 4'(ra0); v.ra1 = 4'(ra1);
      v.e0  = 8'(e0);  v.e1  = 8'(e1);  v.ep = 2'(ep);
      return v;
   endfunction

   function automatic logic addr_ok(input logic [3:0] a);
`ifdef REGFILE_ZERO_REG_EN
      return a != 4'd0;
`else
      return a == a;
`endif
   endfunction

   // What a read port should show this cycle, from model + live inputs
   task automatic exp_port(input logic [3:0] a, output logic [7:0] d,
                           output logic p);
      logic h0, h1;
      d  = mreg[a];
      p  = mpend[a];
      h0 = WriteEn0 && (Waddr0 == a) && addr_ok(a);
      h1 = WriteEn1 && (Waddr1 == a) && addr_ok(a);
      if (msw < 0 && (h0 || h1)) begin
         d = h0 ? DataIn0 : DataIn1;
         if (!(IssueEn && IssueAddr == a)) p = 1'b0;
      end
      if (!addr_ok(a)) begin
         d = 8'h00;
         p = 1'b0;
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < 16; j++) begin
         mreg[j]  = 8'h00;
         mpend[j] = 1'b0;
      end
      msw = -1;
   endtask

   // Advance the model by one clock edge using the inputs held across it
   task automatic model_edge();
      if (Reset) begin
         model_reset();
      end else if (msw >= 0) begin
         mreg[msw]  = 8'h00;
         mpend[msw] = 1'b0;
         msw = (msw == 15) ? -1 : msw + 1;
      end else begin
         if (WriteEn1 && addr_ok(Waddr1)) mreg[Waddr1] = DataIn1;
         if (WriteEn0 && addr_ok(Waddr0)) mreg[Waddr0] = DataIn0;
         if (WriteEn0 && addr_ok(Waddr0)) mpend[Waddr0] = 1'b0;
         if (WriteEn1 && addr_ok(Waddr1)) mpend[Waddr1] = 1'b0;
         if (IssueEn && addr_ok(IssueAddr)) mpend[IssueAddr] = 1'b1;
         if (ClearReq) msw = 0;
      end
   endtask

   task automatic check_all_zero(input string nm);
      for (int a = 0; a < 16; a++) begin
         Raddr = {4'(a), 4'(a)};
         #1;
         chk($sformatf("%s_r%0d", nm, a), {Pending, DataOut}, 20'h0);
      end
   endtask

   task automatic fill_ff();
      for (int a = 0; a < 16; a++) begin
         WriteEn0 = 1'b1;
         Waddr0   = 4'(a);
         DataIn0  = 8'hFF;
         tick();
      end
      idle_in();
   endtask

   initial begin
      logic [7:0] ed0, ed1;
      logic       ep0, ep1;

      tbl[0]  = mk(1, 3, 'hA5, 0, 0, 0,     0, 0, 0, 3, 'h00, 'hA5, 0);
      tbl[1]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 3, 7, 'hA5, 'h00, 0);
      tbl[2]  = mk(1, 7, 'h11, 1, 7, 'h22, 0, 0, 7, 3, 'h11, 'hA5, 0);
      tbl[3]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 7, 7, 'h11, 'h11, 0);
      tbl[4]  = mk(0, 0, 0,     0, 0, 0,     1, 5, 5, 5, 'h00, 'h00, 0);
      tbl[5]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 5, 5, 'h00, 'h00, 3);
      tbl[6]  = mk(0, 0, 0,     1, 5, 'h3C, 0, 0, 5, 3, 'h3C, 'hA5, 0);
      tbl[7]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 5, 5, 'h3C, 'h3C, 0);
      tbl[8]  = mk(1, 5, 'h77, 0, 0, 0,     1, 5, 5, 5, 'h77, 'h77, 0);
      tbl[9]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 5, 5, 'h77, 'h77, 3);
      tbl[10] = mk(0, 0, 0,     1, 9, 'h42, 0, 0, 9, 5, 'h42, 'h77, 2);
      tbl[11] = mk(0, 0, 0,     0, 0, 0,     0, 0, 9, 1, 'h42, 'h00, 0);
      tbl[12] = mk(1, 0, 'h55, 0, 0, 0,     1, 0, 0, 5, R0V, 'h77, 2);
      tbl[13] = mk(0, 0, 0,     0, 0, 0,     0, 0, 0, 5, R0V, 'h77,
                   {1'b1, R0P});

      idle_in();
      Raddr = '0;
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      #1;
      chk("reset_busy", {19'h0, Busy}, 20'h0);
      check_all_zero("reset");

      for (int i = 0; i < 14; i++) begin
         WriteEn0  = tbl[i].we0; Waddr0 = tbl[i].wa0; DataIn0 = tbl[i].d0;
         WriteEn1  = tbl[i].we1; Waddr1 = tbl[i].wa1; DataIn1 = tbl[i].d1;
         IssueEn   = tbl[i].iss; IssueAddr = tbl[i].ia;
         Raddr     = {tbl[i].ra1, tbl[i].ra0};
         #1;
         chk($sformatf("vec%0d", i), {Pending, DataOut},
             {2'b00, tbl[i].ep, tbl[i].e1, tbl[i].e0});
         tick();
      end
      idle_in();

      fill_ff();
      ClearReq = 1'b1;
      tick();
      ClearReq = 1'b0;
      for (int c = 0; c < 16; c++) begin
         idle_in();
         ClearReq = (c == 3);
         if (c == 8) begin
            WriteEn0 = 1'b1; Waddr0 = 4'd15; DataIn0 = 8'h99;
            WriteEn1 = 1'b1; Waddr1 = 4'd3;  DataIn1 = 8'h33;
            IssueEn  = 1'b1; IssueAddr = 4'd2;
         end
         Raddr = {(c == 8) ? 4'd3 : 4'(c - 1), 4'(c)};
         #1;
         chk($sformatf("sweep_busy%0d", c), {19'h0, Busy}, 20'h1);
         chk($sformatf("sweep_ahead%0d", c), {12'h0, DataOut[7:0]},
             {12'h0, (c == 0) ? R0FF : 8'hFF});
         if (c > 0)
            chk($sformatf("sweep_done%0d", c), {12'h0, DataOut[15:8]}, 20'h0);
         tick();
      end
      idle_in();
      #1;
      chk("sweep_end_busy", {19'h0, Busy}, 20'h0);
      check_all_zero("sweep");

      fill_ff();
      ClearReq = 1'b1;
      tick();
      ClearReq = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      chk("abort_busy_pre", {19'h0, Busy}, 20'h1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      #1;
      chk("abort_busy", {19'h0, Busy}, 20'h0);
      check_all_zero("abort");

      model_reset();
      for (int n = 0; n < 600; n++) begin
         Reset     = ($urandom_range(0, 199) == 0);
         ClearReq  = ($urandom_range(0, 39) == 0);
         WriteEn0  = 1'($urandom_range(0, 1));
         Waddr0    = 4'($urandom_range(0, 15));
         DataIn0   = 8'($urandom);
         WriteEn1  = 1'($urandom_range(0, 1));
         Waddr1    = ($urandom_range(0, 3) == 0) ? Waddr0
                                                 : 4'($urandom_range(0, 15));
         DataIn1   = 8'($urandom);
         IssueEn   = 1'($urandom_range(0, 1));
         IssueAddr = ($urandom_range(0, 3) == 0) ? Waddr0
                                                 : 4'($urandom_range(0, 15));
         Raddr     = 8'($urandom);
         #1;
         exp_port(Raddr[3:0], ed0, ep0);
         exp_port(Raddr[7:4], ed1, ep1);
         chk($sformatf("rnd%0d", n), {1'b0, Busy, Pending, DataOut},
             {1'b0, (msw >= 0), ep1, ep0, ed1, ed0});
         @(posedge Clk);
         model_edge();
         #1;
      end
      Reset = 1'b0;
      idle_in();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file that replaces the single-write, two-read processor register file.
- Configurable number of read ports.
- Two write ports with fixed priority.
- Optional write-to-read bypass.
- Per-register pending-write scoreboard for hazard detection.
- Sequenced bulk-clear engine.
Sits between decode (reads/issue) and writeback (two result buses).

Parameters:
W, 8, data path width
A, 4, address width; depth = 2**A registers
NR, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only

Ports:
Clk  input  1  clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
ClearReq  input  1  pulse; starts bulk-clear sweep
Busy  output  1  high while sweep in progress
WriteEn0  input  1  write port 0 enable (higher priority)
Waddr0  input  A  write port 0 address
DataIn0  input  W  write port 0 data
WriteEn1  input  1  write port 1 enable
Waddr1  input  A  write port 1 address
DataIn1  input  W  write port 1 data
IssueEn  input  1  mark register pending
IssueAddr  input  A  register to mark pending
Raddr  input  NR*A  packed read addresses; port i = bits [i*A +: A]
DataOut  output  NR*W  packed read data; port i = bits [i*W +: W]
Pending  output  NR  pending bit for each read port's address

Behaviour:
- Reset (Clk, Reset: synchronous, active-high) clears:
  - all registers to 0 and all pending bits to 0;
  - FSM to IDLE, sweep counter to 0, Busy = 0.
  - Reset overrides every other input, including mid-sweep; sweep is abandoned.
- Reads: combinational, zero latency.
  - DataOut[i] = Registers[Raddr[i]].
- BYPASS=1 forwarding:
  - If WriteEn0 && Waddr0==Raddr[i], DataOut[i]=DataIn0.
  - Else if WriteEn1 && Waddr1==Raddr[i], DataOut[i]=DataIn1.
  - Bypass is suppressed while Busy.
- Writes, posedge:
  - Each enabled port writes its register.
  - Waddr0==Waddr1 with both enabled: port 0 data stored, port 1 dropped.
- Scoreboard, posedge:
  - IssueEn sets pend[IssueAddr].
  - Any enabled write clears pend[Waddr].
  - Issue and write to the same address in the same cycle: set wins.
- Pending output:
  - Pending[i] = pend[Raddr[i]].
  - With BYPASS=1, Pending[i] is forced 0 when an enabled write matches Raddr[i] that cycle and no same-address issue is present.
- FSM states:
  - IDLE: ClearReq -> SWEEP, counter = 0.
  - SWEEP: each cycle, Registers[cnt] <= 0, pend[cnt] <= 0, cnt++; at cnt == 2**A-1, clear that entry and return to IDLE.
- Busy = (state == SWEEP); high for exactly 2**A cycles, beginning the cycle after ClearReq.
- During SWEEP:
  - write-port and issue inputs are ignored (dropped, not queued);
  - ClearReq is ignored;
  - reads return current, partially-cleared contents.
- Counter is A bits wide; terminal compare is on the all-ones value, so no wrap-around occurs.

Optional Feature:
Macro REGFILE_ZERO_REG_EN.
- Defined:
  - register 0 reads as 0 on every port, including bypass;
  - writes to address 0 are discarded;
  - IssueEn to address 0 is ignored, so Pending is always 0 for address 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
All scenarios use W=8, A=4, NR=2, BYPASS=1.
- Reset then read all 16 addresses -> DataOut 0x00 and Pending 0 on both ports.
- Write0 r3=0xA5; next cycle Raddr0=3 -> 0xA5. In the same write cycle with Raddr1=3 -> bypass gives 0xA5 combinationally.
- WriteEn0 r7=0x11 and WriteEn1 r7=0x22 in the same cycle -> r7 reads 0x11 afterwards.
- IssueEn r5 -> Pending=1 next cycle; Write1 r5=0x3C -> Pending=0 in that cycle (bypass) and after. Simultaneous issue and write to r5 -> Pending stays 1 and r5=write data.
- Fill r0..r15 with 0xFF, pulse ClearReq:
  - Busy high for 16 cycles;
  - mid-sweep (cycle 8) a write to r15 is dropped;
  - after sweep all registers read 0x00.
  - Repeat with Reset asserted at cycle 5 of the sweep -> Busy 0 and all registers 0 the next cycle.
- With REGFILE_ZERO_REG_EN: write r0=0x55 and IssueEn r0 -> r0 reads 0x00 and Pending 0. Without the macro: r0 reads 0x55.
